instruction_fetch: RTL and testbench

Fetch stage sitting directly downstream of `program_counter`. It reads the current 16-bit `pc` and issues a single-outstanding read request to instruction memory. It captures the returned 19-bit instruction into an instruction register and presents it to decode with a valid/ready handshake. It drives `pc_enable` to advance or redirect the PC only when decode consumes an instruction, and it flags a sticky error if memory fails to answer within a bounded number of cycles.

---
 rtl/instruction_fetch.sv | 100 ++++++++++
 tb/tb_instruction_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory read, instruction register
// with valid/ready handshake to decode, and a sticky timeout error.
module instruction_fetch #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 19,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               halt,
  output logic               pc_enable,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         cnt_q;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next state is defaulted first so no path through the case can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!halt) state_nxt = REQ;
      REQ: begin
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (mem_ack)                state_nxt = FULL;
        else if (cnt_q == CNT_LAST) state_nxt = ERR;
      end
      FULL:    if (ir_ready) state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halt) begin
            addr_q <= pc;
            cnt_q  <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            ir_q    <= mem_rdata;
            ir_pc_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode directly from the state register, so reset clears them
  // asynchronously along with the state.
  assign mem_req   = (state == REQ);
  assign mem_addr  = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = (state == FULL);
  assign pc_enable = (state == FULL) && ir_ready;
  assign fetch_err = (state == ERR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed fetch scenarios against a
// program_counter model and a latency-programmable instruction memory model.
module tb_instruction_fetch;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 19;

  logic               clk;
  logic               rst;
  logic [ADDR_W-1:0]  pc;
  logic               halt;
  logic               pc_enable;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               ir_ready;
  logic               fetch_err;

  instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .halt      (halt),
    .pc_enable (pc_enable),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .fetch_err (fetch_err)
  );

  typedef struct {
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] req_log[$];
  int                len_log[$];
  int                pe_log[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  int                lat       = 1;   // REQ cycles up to and including the ack; 0 = never ack
  int                rsp_cnt   = 0;
  logic              force_ack = 1'b0;
  logic              pc_load   = 1'b0;
  logic [ADDR_W-1:0] pc_load_val = '0;
  logic              redirect  = 1'b0;
  logic [ADDR_W-1:0] target    = '0;
  logic              mon_prev_req = 1'b0;
  int                mon_req_len  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0000: return 19'h00011;
      16'h0001: return 19'h12345;
      16'h0002: return 19'h4F00F;
      16'h00A5: return 19'h7ABCD;
      16'h0010: return 19'h2C0DE;
      16'h0011: return 19'h00777;
      16'h1234: return 19'h31234;
      default:  return 19'h0DEAD;
    endcase
  endfunction

  // program_counter model: +1 on pc_enable, or jump to target when redirected.
  always @(posedge clk or posedge rst) begin
    if (rst)            pc <= '0;
    else if (pc_load)   pc <= pc_load_val;
    else if (pc_enable) pc <= redirect ? target : pc + 16'd1;
  end

  // Memory responder: answers after lat REQ cycles; force_ack injects stray acks.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (lat != 0 && rsp_cnt + 1 >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          rsp_cnt   = 0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = '0;
          rsp_cnt++;
        end
      end else begin
        mem_ack   = force_ack;
        mem_rdata = force_ack ? 19'h7FFFF : '0;
        rsp_cnt   = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: logs request starts/lengths and pc_enable cycles; scores handshakes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      cycle++;
      if (rst) begin
        mon_prev_req = 1'b0;
        mon_req_len  = 0;
      end else begin
        if (mem_req && !mon_prev_req) req_log.push_back(mem_addr);
        if (mem_req) mon_req_len++;
        else if (mon_prev_req) begin
          len_log.push_back(mon_req_len);
          mon_req_len = 0;
        end
        mon_prev_req = mem_req;
        if (pc_enable) pe_log.push_back(cycle);
        if (ir_valid && ir_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: handshake ir=0x%0h ir_pc=0x%0h with nothing expected", ir, ir_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_ir", 32'(ir), 32'(e.ir));
            check("sb_ir_pc", 32'(ir_pc), 32'(e.pc));
            check("sb_pc_enable", 32'(pc_enable), 32'd1);
          end
        end
      end
    end
  end

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic smp();
    #3;
  endtask

  function automatic bit cond(input int sel, input int n);
    case (sel)
      0:       return mem_req;
      1:       return !mem_req;
      2:       return ir_valid;
      default: return pe_log.size() >= n;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int n, input string name);
    int k = 0;
    while (!cond(sel, n) && k < 64) begin
      adv();
      smp();
      k++;
    end
    if (!cond(sel, n)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: condition not met after %0d cycles, required within 64", name, k);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    len_log.delete();
    pe_log.delete();
  endtask

  initial begin
    logic [INSTR_W-1:0] held_ir;
    bit ok_valid, ok_stable, ok_pe, ok_req;

    rst = 1'b1; halt = 1'b0; ir_ready = 1'b1;
    repeat (2) @(negedge clk);
    smp();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_pc_enable", 32'(pc_enable), 0);
    check("rst_fetch_err", 32'(fetch_err), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_ir_pc", 32'(ir_pc), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);

    // Zero-wait memory, ir_ready tied high, three back-to-back fetches.
    exp_q.push_back('{19'h00011, 16'h0000});
    exp_q.push_back('{19'h12345, 16'h0001});
    exp_q.push_back('{19'h4F00F, 16'h0002});
    clear_logs();
    adv(); rst = 1'b0; smp();
    check("t1_idle_cycle0_req", 32'(mem_req), 0);
    adv(); smp();
    check("t1_req_cycle1", 32'(mem_req), 1);
    check("t1_addr_cycle1", 32'(mem_addr), 32'h0000);
    wait_until(3, 3, "t1_three_pulses");
    adv(); halt = 1'b1; smp();
    check("t1_req_count", 32'(req_log.size()), 3);
    if (req_log.size() == 3) begin
      check("t1_addr0", 32'(req_log[0]), 32'h0000);
      check("t1_addr1", 32'(req_log[1]), 32'h0001);
      check("t1_addr2", 32'(req_log[2]), 32'h0002);
    end
    check("t1_pulse_count", 32'(pe_log.size()), 3);
    if (pe_log.size() == 3) begin
      check("t1_pulse_gap01", 32'(pe_log[1] - pe_log[0]), 3);
      check("t1_pulse_gap12", 32'(pe_log[2] - pe_log[1]), 3);
    end

    // 4-cycle ack latency at 0x00A5; halt during REQ must not cancel the fetch.
    adv(); pc_load = 1'b1; pc_load_val = 16'h00A5; lat = 4; smp();
    check("t2_parked", 32'(mem_req), 0);
    adv(); pc_load = 1'b0; halt = 1'b0; clear_logs();
    exp_q.push_back('{19'h7ABCD, 16'h00A5});
    smp();
    wait_until(0, 0, "t2_req_start");
    adv(); halt = 1'b1; smp();
    wait_until(1, 0, "t2_req_end");
    check("t2_ir_valid_next", 32'(ir_valid), 1);
    check("t2_ir", 32'(ir), 32'h7ABCD);
    check("t2_ir_pc", 32'(ir_pc), 32'h00A5);
    check("t2_req_len", 32'(len_log.size() > 0 ? len_log[0] : 0), 4);
    check("t2_req_addr", 32'(req_log.size() > 0 ? req_log[0] : 16'hFFFF), 32'h00A5);

    // Backpressure: ir_ready low for 10 cycles in FULL.
    adv(); pc_load = 1'b1; pc_load_val = 16'h0010; lat = 1; ir_ready = 1'b0; smp();
    adv(); pc_load = 1'b0; halt = 1'b0; clear_logs();
    exp_q.push_back('{19'h2C0DE, 16'h0010});
    smp();
    wait_until(0, 0, "t3_req_start");
    adv(); halt = 1'b1; smp();
    wait_until(2, 0, "t3_full");
    held_ir = ir;
    ok_valid = 1; ok_stable = 1; ok_pe = 1; ok_req = 1;
    for (int i = 0; i < 10; i++) begin
      adv(); smp();
      if (ir_valid !== 1'b1) ok_valid = 0;
      if (ir !== held_ir) ok_stable = 0;
      if (pc_enable !== 1'b0) ok_pe = 0;
      if (mem_req !== 1'b0) ok_req = 0;
    end
    check("t3_held_ir", 32'(held_ir), 32'h2C0DE);
    check("t3_valid_held", 32'(ok_valid), 1);
    check("t3_ir_stable", 32'(ok_stable), 1);
    check("t3_no_pc_enable", 32'(ok_pe), 1);
    check("t3_no_mem_req", 32'(ok_req), 1);
    adv(); ir_ready = 1'b1; smp();
    check("t3_pulse_on_ready", 32'(pc_enable), 1);
    adv(); smp();
    check("t3_pulse_single", 32'(pc_enable), 0);
    check("t3_valid_cleared", 32'(ir_valid), 0);
    check("t3_ir_retained", 32'(ir), 32'h2C0DE);
    check("t3_ir_pc_retained", 32'(ir_pc), 32'h0010);
    check("t3_parked", 32'(mem_req), 0);
    check("t3_pulse_total", 32'(pe_log.size()), 1);

    // Redirect on the handshake: next fetch must use the jump target.
    adv(); redirect = 1'b1; target = 16'h1234; halt = 1'b0; clear_logs();
    exp_q.push_back('{19'h00777, 16'h0011});
    exp_q.push_back('{19'h31234, 16'h1234});
    smp();
    wait_until(3, 1, "t4_first_handshake");
    adv(); redirect = 1'b0; smp();
    wait_until(0, 0, "t4_second_req");
    check("t4_redirect_addr", 32'(mem_addr), 32'h1234);
    adv(); halt = 1'b1; smp();
    wait_until(3, 2, "t4_second_handshake");
    check("t4_req_count", 32'(req_log.size()), 2);
    if (req_log.size() == 2) begin
      check("t4_addr0", 32'(req_log[0]), 32'h0011);
      check("t4_addr1", 32'(req_log[1]), 32'h1234);
    end
    adv(); smp();
    adv(); smp();
    check("t4_parked_halt", 32'(mem_req), 0);

    // Ack on the last allowed REQ cycle (TIMEOUT=8): ack wins; resume after halt drops.
    adv(); lat = 8; halt = 1'b0; clear_logs();
    exp_q.push_back('{19'h0DEAD, 16'h1235});
    smp();
    check("t5_idle_at_release", 32'(mem_req), 0);
    adv(); smp();
    check("t5_resume_req", 32'(mem_req), 1);
    check("t5_resume_addr", 32'(mem_addr), 32'h1235);
    adv(); halt = 1'b1; smp();
    wait_until(1, 0, "t5_req_end");
    check("t5_no_err", 32'(fetch_err), 0);
    check("t5_valid", 32'(ir_valid), 1);
    check("t5_req_len", 32'(len_log.size() > 0 ? len_log[0] : 0), 8);

    // Memory never answers: error after 8 REQ cycles, sticky until reset.
    adv(); lat = 0; halt = 1'b0; clear_logs(); smp();
    wait_until(0, 0, "t6_req_start");
    check("t6_addr", 32'(mem_addr), 32'h1236);
    adv(); halt = 1'b1; smp();
    wait_until(1, 0, "t6_req_end");
    check("t6_req_len", 32'(len_log.size() > 0 ? len_log[0] : 0), 8);
    check("t6_fetch_err", 32'(fetch_err), 1);
    check("t6_ir_valid", 32'(ir_valid), 0);
    check("t6_pc_enable", 32'(pc_enable), 0);
    adv(); force_ack = 1'b1; halt = 1'b0; smp();
    adv(); force_ack = 1'b0; smp();
    repeat (3) begin adv(); smp(); end
    check("t6_err_sticky", 32'(fetch_err), 1);
    check("t6_late_ack_valid", 32'(ir_valid), 0);
    check("t6_late_ack_ir", 32'(ir), 32'h0DEAD);
    check("t6_err_no_req", 32'(mem_req), 0);
    adv(); #1 rst = 1'b1; #1;
    check("t6_rst_clears_err", 32'(fetch_err), 0);
    check("t6_rst_ir", 32'(ir), 0);
    check("t6_rst_ir_pc", 32'(ir_pc), 0);

    // Async reset mid-FULL, then a stray ack after reset.
    adv(); rst = 1'b0; halt = 1'b0; lat = 1; ir_ready = 1'b0; smp();
    wait_until(2, 0, "t7_full");
    check("t7_ir_before_rst", 32'(ir), 32'h00011);
    adv(); #1 rst = 1'b1; #1;
    check("t7_rst_valid", 32'(ir_valid), 0);
    check("t7_rst_ir", 32'(ir), 0);
    check("t7_rst_ir_pc", 32'(ir_pc), 0);
    check("t7_rst_req", 32'(mem_req), 0);
    adv(); rst = 1'b0; halt = 1'b1; smp();
    adv(); force_ack = 1'b1; smp();
    adv(); force_ack = 1'b0; smp();
    adv(); smp();
    check("t7_late_ack_ir", 32'(ir), 0);
    check("t7_late_ack_valid", 32'(ir_valid), 0);
    check("t7_late_ack_req", 32'(mem_req), 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
